aes_input_fifo: RTL and testbench

- Upstream stage of the AES controller: accepts 128-bit blocks from a 32-bit host write port, assembles four words into one in_packet_t, and buffers packets in a small FIFO.
- Presents the head packet to the controller's data_in and pops on the controller's load_data.
- Handles the controller's key-load protocol:
  - set_key packets are presented for exactly one cycle.
  - A following set_key packet is held off until key expansion has finished.

---
 rtl/aes_input_fifo_pkg.sv | 26 ++
 rtl/aes_pkt_fifo.sv | 56 +++++
 rtl/aes_input_fifo.sv | 105 ++++++++++
 tb/tb_aes_input_fifo.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_input_fifo_pkg.sv
// Shared AES controller definitions: block geometry, key schedule length
// and the packet handed from the input FIFO to the controller.
package aes_input_fifo_pkg;

  localparam int AES_WORDS_PER_BLOCK = 4;
  localparam int AES_KEY_GEN_CYCLES  = 11;

  typedef struct packed {
    logic         valid;
    logic         set_key;
    logic         en_de;
    logic [127:0] data;
  } in_packet_t;

  // Build a stored packet from latched flags and the four assembled words.
  function automatic in_packet_t make_packet(input logic sk, input logic ende,
                                             input logic [127:0] blk);
    in_packet_t p;
    p.valid   = 1'b1;
    p.set_key = sk;
    p.en_de   = ende;
    p.data    = blk;
    return p;
  endfunction

endpackage

// File: rtl/aes_pkt_fifo.sv
// Generic synchronous FIFO of in_packet_t with push, pop, flush and count.
module aes_pkt_fifo
  import aes_input_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  in_packet_t               push_pkt,
  input  logic                     pop,
  output in_packet_t               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  in_packet_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & (~full | pop) & ~rst & ~flush;
  assign pop_ok  = pop & ~empty & ~rst & ~flush;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush clears like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Packet storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_pkt;
  end

endmodule

// File: rtl/aes_input_fifo.sv
// Host-side input stage of the AES controller: assembles 32-bit words into
// 128-bit packets, queues them and applies the key-load presentation rules.
module aes_input_fifo
  import aes_input_fifo_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int KEY_HOLDOFF = AES_KEY_GEN_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [31:0]              wr_data,
  input  logic                     wr_set_key,
  input  logic                     wr_en_de,
  output in_packet_t               data_out,
  input  logic                     load_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               word_idx
);

  localparam int HW = $clog2(KEY_HOLDOFF + 1);

  logic [95:0]     words;
  logic            key_lat;
  logic            ende_lat;
  logic [HW-1:0]   holdoff;
  logic            wr_acc;
  logic            push;
  in_packet_t      push_pkt;
  logic            pop;
  logic            present;
  logic            key_pop;
  in_packet_t      head;
  logic            full;
  logic            empty;

  // Words are accepted whenever the queue has room, so word 3 never stalls.
  assign wr_ready = ~rst & ~full;
  assign wr_acc   = wr_valid & wr_ready & ~flush;
  assign push     = wr_acc & (word_idx == 2'(AES_WORDS_PER_BLOCK - 1));
  assign push_pkt = make_packet(key_lat, ende_lat, {words, wr_data});

  // Only key heads are held back while the previous key is still expanding.
  assign present  = ~rst & ~empty & head.valid & ~(head.set_key & (holdoff != '0));
  assign key_pop  = present & head.set_key;
  assign pop      = present & (head.set_key | load_data);

  aes_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .push_pkt (push_pkt),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Head presentation: payload zeroed unless the packet is actually offered.
  always_comb begin
    data_out = '0;
    if (!rst && !empty) begin
      data_out.set_key = head.set_key;
      if (present) begin
        data_out.valid = 1'b1;
        data_out.en_de = head.en_de;
        data_out.data  = head.data;
      end
    end
  end

  // Word position within the block being assembled.
  always_ff @(posedge clk) begin
    if (rst || flush) word_idx <= '0;
    else if (wr_acc)  word_idx <= word_idx + 2'd1;
  end

  // Capture the first three words and the per-packet flags from word 0.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      case (word_idx)
        2'd0: begin
          words[95:64] <= wr_data;
          key_lat      <= wr_set_key;
          ende_lat     <= wr_en_de;
        end
        2'd1:    words[63:32] <= wr_data;
        2'd2:    words[31:0]  <= wr_data;
        default: ;
      endcase
    end
  end

  // Key-expansion holdoff: reloaded on every key pop, then counts down.
  always_ff @(posedge clk) begin
    if (rst || flush)          holdoff <= '0;
    else if (key_pop)          holdoff <= HW'(KEY_HOLDOFF);
    else if (holdoff != '0)    holdoff <= holdoff - HW'(1);
  end

endmodule

// File: tb/tb_aes_input_fifo.sv
// Bench for aes_input_fifo: queue-based reference model checked every cycle,
// plus directed literal expectations for each scenario.
module tb_aes_input_fifo;
  import aes_input_fifo_pkg::*;

  localparam int DEPTH = 4;
  localparam int KH    = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_set_key = 1'b0;
  logic        wr_en_de = 1'b0;
  logic        load_data = 1'b0;
  logic        wr_ready;
  in_packet_t  data_out;
  logic [2:0]  count;
  logic [1:0]  word_idx;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  aes_input_fifo #(.DEPTH(DEPTH), .KEY_HOLDOFF(KH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_set_key (wr_set_key),
    .wr_en_de   (wr_en_de),
    .data_out   (data_out),
    .load_data  (load_data),
    .count      (count),
    .word_idx   (word_idx)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  in_packet_t  mq[$];
  int          mhold = 0;
  int          mwidx = 0;
  logic [31:0] mw [4];
  logic        msk = 1'b0;
  logic        mende = 1'b0;

  always @(posedge clk) begin
    bit pres, popk, popd, acc;
    in_packet_t p;
    if (rst || flush) begin
      mq.delete();
      mhold = 0;
      mwidx = 0;
    end else begin
      pres = (mq.size() > 0) && !(mq[0].set_key && mhold != 0);
      popk = pres && mq[0].set_key;
      popd = pres && !mq[0].set_key && load_data;
      acc  = wr_valid && (mq.size() < DEPTH);
      if (popk) mhold = KH;
      else if (mhold > 0) mhold--;
      if (popk || popd) void'(mq.pop_front());
      if (acc) begin
        if (mwidx == 0) begin
          msk   = wr_set_key;
          mende = wr_en_de;
        end
        mw[mwidx] = wr_data;
        if (mwidx == 3) begin
          p.valid   = 1'b1;
          p.set_key = msk;
          p.en_de   = mende;
          p.data    = {mw[0], mw[1], mw[2], mw[3]};
          mq.push_back(p);
        end
        mwidx = (mwidx + 1) % 4;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit ev, ne;
    logic esk, eende;
    logic [127:0] edata;
    if (chk_en) begin
      ne    = (mq.size() > 0) && !rst;
      ev    = ne && !(mq[0].set_key && mhold != 0);
      esk   = ne ? mq[0].set_key : 1'b0;
      eende = ev ? mq[0].en_de : 1'b0;
      edata = ev ? mq[0].data : '0;
      chk("valid",    128'(data_out.valid),   128'(ev));
      chk("set_key",  128'(data_out.set_key), 128'(esk));
      chk("en_de",    128'(data_out.en_de),   128'(eende));
      chk("data",     data_out.data,          edata);
      chk("count",    128'(count),            128'(mq.size()));
      chk("word_idx", 128'(word_idx),         128'(mwidx));
      chk("wr_ready", 128'(wr_ready),         128'(!rst && mq.size() < DEPTH));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_word(input logic [31:0] d, input logic sk, input logic ende);
    int n;
    n = 0;
    wr_valid   = 1'b1;
    wr_data    = d;
    wr_set_key = sk;
    wr_en_de   = ende;
    while (!wr_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL wr_ready_timeout: got 0 expected 1 at %0t", $time);
    end
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [127:0] blk, input logic sk, input logic ende);
    send_word(blk[127:96], sk, ende);
    send_word(blk[95:64],  1'b0, 1'b0);
    send_word(blk[63:32],  1'b0, 1'b0);
    send_word(blk[31:0],   1'b0, 1'b0);
  endtask

  function automatic logic [127:0] pat(input int i);
    return {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i),
            32'h3000_0000 + 32'(i), 32'h4000_0000 + 32'(i)};
  endfunction

  // ---------------- directed scenarios ----------------
  initial begin
    logic [127:0] blk;
    int zeros;
    int k;

    tick();
    chk_en = 1'b1;
    chk("rst_count",    128'(count),    128'd0);
    chk("rst_word_idx", 128'(word_idx), 128'd0);
    chk("rst_data_out", 128'(data_out), 128'd0);
    chk("rst_wr_ready", 128'(wr_ready), 128'd0);
    rst = 1'b0;
    tick();

    // Single data packet, held with load_data low.
    send_pkt(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0, 1'b1);
    chk("t1_valid", 128'(data_out.valid), 128'd1);
    chk("t1_data",  data_out.data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("t1_en_de", 128'(data_out.en_de), 128'd1);
    chk("t1_count", 128'(count), 128'd1);
    idle(5);
    chk("t1_hold_valid", 128'(data_out.valid), 128'd1);
    chk("t1_hold_count", 128'(count), 128'd1);
    load_data = 1'b1;
    tick();
    load_data = 1'b0;
    chk("t1_pop_count", 128'(count), 128'd0);

    // Key then data: key pops by itself, data waits for load_data.
    send_pkt(128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3, 1'b1, 1'b1);
    chk("t2_key_valid", 128'(data_out.valid),   128'd1);
    chk("t2_key_sk",    128'(data_out.set_key), 128'd1);
    send_pkt(128'h11111111_22222222_33333333_44444444, 1'b0, 1'b1);
    chk("t2_data_valid", 128'(data_out.valid), 128'd1);
    chk("t2_data_sk",    128'(data_out.set_key), 128'd0);
    chk("t2_data",       data_out.data, 128'h11111111_22222222_33333333_44444444);
    idle(3);
    chk("t2_held_count", 128'(count), 128'd1);
    load_data = 1'b1;
    tick();
    load_data = 1'b0;
    chk("t2_pop_count", 128'(count), 128'd0);
    idle(15);

    // Back-to-back keys: second key blocked for the full holdoff.
    send_pkt(128'hCAFE0000_CAFE0001_CAFE0002_CAFE0003, 1'b1, 1'b0);
    chk("t3_ka_valid", 128'(data_out.valid), 128'd1);
    send_pkt(128'hBEEF0000_BEEF0001_BEEF0002_BEEF0003, 1'b1, 1'b1);
    // Three blocked cycles elapsed while key B was being written.
    zeros = 0;
    while (data_out.valid == 1'b0 && zeros < 50) begin
      zeros++;
      tick();
    end
    chk("t3_blocked_cycles", 128'(zeros + 3), 128'd11);
    chk("t3_kb_valid", 128'(data_out.valid), 128'd1);
    chk("t3_kb_data",  data_out.data, 128'hBEEF0000_BEEF0001_BEEF0002_BEEF0003);
    tick();
    chk("t3_kb_popped", 128'(count), 128'd0);
    chk("t3_kb_gone",   128'(data_out.valid), 128'd0);
    idle(15);

    // Fill, pop with word 0 pending, then wrap through ten packets.
    for (int i = 0; i < 4; i++) send_pkt(pat(i), 1'b0, 1'b1);
    chk("t4_full_count", 128'(count), 128'd4);
    chk("t4_full_ready", 128'(wr_ready), 128'd0);
    blk        = pat(4);
    wr_valid   = 1'b1;
    wr_data    = blk[127:96];
    wr_set_key = 1'b0;
    wr_en_de   = 1'b1;
    load_data  = 1'b1;
    tick();
    load_data = 1'b0;
    chk("t4_after_pop_count", 128'(count), 128'd3);
    chk("t4_after_pop_ready", 128'(wr_ready), 128'd1);
    chk("t4_after_pop_widx",  128'(word_idx), 128'd0);
    send_pkt(pat(4), 1'b0, 1'b1);
    for (int i = 5; i < 10; i++) begin
      load_data = 1'b1;
      tick();
      load_data = 1'b0;
      send_pkt(pat(i), 1'b0, 1'b1);
    end
    k = 6;
    while (count != 0 && k < 20) begin
      chk("t4_drain_valid", 128'(data_out.valid), 128'd1);
      chk("t4_drain_data",  data_out.data, pat(k));
      load_data = 1'b1;
      tick();
      load_data = 1'b0;
      k++;
    end
    chk("t4_drained", 128'(k), 128'd10);

    // Flush mid-assembly with two packets queued.
    send_pkt(pat(20), 1'b0, 1'b1);
    send_pkt(pat(21), 1'b0, 1'b1);
    blk = pat(22);
    send_word(blk[127:96], 1'b0, 1'b1);
    send_word(blk[95:64],  1'b0, 1'b0);
    chk("t5_widx2", 128'(word_idx), 128'd2);
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = blk[63:32];
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    chk("t5_count", 128'(count), 128'd0);
    chk("t5_widx",  128'(word_idx), 128'd0);
    chk("t5_valid", 128'(data_out.valid), 128'd0);
    send_pkt(pat(23), 1'b0, 1'b0);
    chk("t5_clean_data",  data_out.data, pat(23));
    chk("t5_clean_en_de", 128'(data_out.en_de), 128'd0);
    load_data = 1'b1;
    tick();
    load_data = 1'b0;

    // Reset coincident with a word-3 write and load_data.
    send_pkt(pat(30), 1'b0, 1'b1);
    blk = pat(31);
    send_word(blk[127:96], 1'b0, 1'b1);
    send_word(blk[95:64],  1'b0, 1'b0);
    send_word(blk[63:32],  1'b0, 1'b0);
    wr_valid  = 1'b1;
    wr_data   = blk[31:0];
    rst       = 1'b1;
    load_data = 1'b1;
    #1;
    chk("t6_rst_data_out", 128'(data_out), 128'd0);
    chk("t6_rst_ready",    128'(wr_ready), 128'd0);
    tick();
    rst       = 1'b0;
    load_data = 1'b0;
    wr_valid  = 1'b0;
    chk("t6_count",    128'(count),    128'd0);
    chk("t6_widx",     128'(word_idx), 128'd0);
    chk("t6_data_out", 128'(data_out), 128'd0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
